color: RTL and testbench
========================

Name: color

Overview:
- Pixel colour lookup for the score display pipeline.
- Maps a per-pixel type code and the active instrument to a 24-bit RGB value (8 bits per channel).
- Sits between the score renderer, which classifies each pixel, and the video output stage.
- Outputs are registered: one clock of latency, with a valid flag carried alongside.

Parameters:
- None. All widths and colour constants are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- pixel_valid  input  1  pixel_type and instrument_type are valid this cycle
- pixel_type  input  5  pixel class flags; see Behaviour
- instrument_type  input  2  active instrument: 00 violin, 01 piano, 10 electric, 11 default
- r  output  8  red channel, registered
- g  output  8  green channel, registered
- b  output  8  blue channel, registered
- color_valid  output  1  r/g/b hold the colour for the pixel accepted on the previous cycle

Behaviour:
- Reset: rst_n low clears r, g, b to 8'h00 and color_valid to 0 immediately, independent of clk. Outputs stay cleared while rst_n is low.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on r/g/b at edge N.
- color_valid at edge N equals the pixel_valid sampled at edge N.
- Inputs sampled with pixel_valid=0: r/g/b load 24'h000000 and color_valid goes 0. There is no hold of the stale colour.
- Pixel class decode, strict priority, highest first:
  - Note pixel: pixel_type[0] or pixel_type[4] is set. Colour depends on instrument_type:
    - 00 (violin) -> FF0000
    - 01 (piano) -> 00FF00
    - 10 (electric) -> 0000FF
    - 11 (default) -> FFFFFF
  - Staff line: pixel_type[1] -> FFFFFF.
  - Text: pixel_type[2] -> FFFFFF.
  - Cursor: pixel_type[3] -> 808080.
  - Background: no bit set -> 000000.
- instrument_type only affects note pixels; it is ignored for every other class.
- Multiple bits set: the highest-priority class wins. Example: 5'b00110 gives text-priority-losing staff, i.e. staff white. Example: 5'b01001 gives the note colour.
- No combinational path from inputs to outputs.
- Continuous streaming at one pixel per cycle; there is no backpressure.
- Reset released mid-stream: the first valid output appears one edge after the first pixel_valid=1 sampled following deassertion.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle with prior output FFFFFF -> r/g/b=000000 and color_valid=0 immediately, without waiting for a clock edge.
- Note per instrument: pixel_valid=1, pixel_type=00001 with instrument 00 -> FF0000. pixel_type=10000 with instruments 01, 10, 11 -> 00FF00, 0000FF, FFFFFF. Each result appears one edge after its input.
- Non-note classes: pixel_type=00010 -> FFFFFF; 00100 -> FFFFFF; 01000 -> 808080; 00000 -> 000000. Repeat each with all four instrument values; the output must be unchanged.
- Priority: 10010 with instrument 10 -> 0000FF; 00110 -> FFFFFF; 01100 -> FFFFFF; 01010 -> FFFFFF.
- Valid gating: pixel_type=00001, instrument 00, pixel_valid=0 -> next edge r/g/b=000000 and color_valid=0.
- Back-to-back streaming: alternate 00001/00000 every cycle with instrument 00 -> outputs alternate FF0000/000000 with 1-cycle lag, and color_valid stays 1 throughout.

Source files
------------

// File: rtl/color.sv
// Pixel colour lookup: pixel class + active instrument -> registered 24-bit RGB.
// One cycle of latency; color_valid travels alongside the colour.
module color (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_valid,
  input  logic [4:0] pixel_type,
  input  logic [1:0] instrument_type,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       color_valid
);

  localparam int STAGES = 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t C_WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t C_GREY  = '{r: 8'h80, g: 8'h80, b: 8'h80};
  localparam rgb_t C_RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t C_GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t C_BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};

  logic [STAGES:0] vld_pipe;
  rgb_t            note_rgb;
  rgb_t            nxt_rgb;
  rgb_t            rgb_q;

  always_comb begin
    note_rgb = C_WHITE;
    unique case (instrument_type)
      2'b00:   note_rgb = C_RED;
      2'b01:   note_rgb = C_GREEN;
      2'b10:   note_rgb = C_BLUE;
      default: note_rgb = C_WHITE;
    endcase
  end

  // Strict priority: note > staff > text > cursor > background.
  // Invalid pixels load black rather than holding the previous colour.
  always_comb begin
    nxt_rgb = C_BLACK;
    if (pixel_valid) begin
      if (pixel_type[0] || pixel_type[4]) nxt_rgb = note_rgb;
      else if (pixel_type[1])             nxt_rgb = C_WHITE;
      else if (pixel_type[2])             nxt_rgb = C_WHITE;
      else if (pixel_type[3])             nxt_rgb = C_GREY;
      else                                nxt_rgb = C_BLACK;
    end
  end

  assign vld_pipe[0] = pixel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rgb_q              <= C_BLACK;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      rgb_q              <= nxt_rgb;
    end
  end

  assign r           = rgb_q.r;
  assign g           = rgb_q.g;
  assign b           = rgb_q.b;
  assign color_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_color.sv
// Directed bench for color: expectations queued at drive time, checked one edge later.
module tb_color;

  logic       clk;
  logic       rst_n;
  logic       pixel_valid;
  logic [4:0] pixel_type;
  logic [1:0] instrument_type;
  logic [7:0] r, g, b;
  logic       color_valid;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        vld;
    logic [23:0] rgb;
    string       tag;
  } exp_t;

  exp_t sb[$];

  color dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_type(pixel_type),
    .instrument_type(instrument_type), .r(r), .g(g), .b(b), .color_valid(color_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ev, input logic [23:0] ergb);
    n_assert++;
    assert ({color_valid, r, g, b} === {ev, ergb})
      else begin
        n_fail++;
        $error("FAIL %s: got vld=%0b rgb=%06h, expected vld=%0b rgb=%06h",
               tag, color_valid, {r, g, b}, ev, ergb);
      end
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk(e.tag, e.vld, e.rgb);
    end
  endtask

  // One stimulus cycle: check what the previous edge produced, then drive new inputs.
  task automatic cycle(input logic v, input logic [4:0] pt, input logic [1:0] it,
                       input logic [23:0] ergb, input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) pop_chk();
    pixel_valid     = v;
    pixel_type      = pt;
    instrument_type = it;
    e.vld = v;
    e.rgb = ergb;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    pop_chk();
    pixel_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    logic [4:0]  nn_pt  [4];
    logic [23:0] nn_rgb [4];
    nn_pt[0] = 5'b00010; nn_rgb[0] = 24'hFFFFFF;
    nn_pt[1] = 5'b00100; nn_rgb[1] = 24'hFFFFFF;
    nn_pt[2] = 5'b01000; nn_rgb[2] = 24'h808080;
    nn_pt[3] = 5'b00000; nn_rgb[3] = 24'h000000;

    rst_n = 1'b0; pixel_valid = 1'b0; pixel_type = '0; instrument_type = '0;
    #1;
    chk("reset_initial", 1'b0, 24'h000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Note colour per instrument
    cycle(1'b1, 5'b00001, 2'b00, 24'hFF0000, "note_violin");
    cycle(1'b1, 5'b10000, 2'b01, 24'h00FF00, "note_piano");
    cycle(1'b1, 5'b10000, 2'b10, 24'h0000FF, "note_electric");
    cycle(1'b1, 5'b10000, 2'b11, 24'hFFFFFF, "note_default");

    // Non-note classes ignore instrument
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++)
        cycle(1'b1, nn_pt[c], 2'(i), nn_rgb[c], $sformatf("class%0d_inst%0d", c, i));

    // Priority
    cycle(1'b1, 5'b10010, 2'b10, 24'h0000FF, "prio_note_over_staff");
    cycle(1'b1, 5'b00110, 2'b00, 24'hFFFFFF, "prio_staff_over_text");
    cycle(1'b1, 5'b01100, 2'b01, 24'hFFFFFF, "prio_text_over_cursor");
    cycle(1'b1, 5'b01010, 2'b10, 24'hFFFFFF, "prio_staff_over_cursor");
    cycle(1'b1, 5'b01001, 2'b01, 24'h00FF00, "prio_note_over_cursor");

    // Valid gating: note pixel with pixel_valid low must give black, valid 0
    cycle(1'b1, 5'b00001, 2'b00, 24'hFF0000, "gate_pre");
    cycle(1'b0, 5'b00001, 2'b00, 24'h000000, "gate_invalid");

    // Back-to-back streaming
    for (int k = 0; k < 8; k++)
      cycle(1'b1, (k % 2 == 0) ? 5'b00001 : 5'b00000, 2'b00,
            (k % 2 == 0) ? 24'hFF0000 : 24'h000000, $sformatf("stream%0d", k));

    // Asynchronous reset mid-cycle with white on the outputs
    cycle(1'b1, 5'b10000, 2'b11, 24'hFFFFFF, "pre_reset_white");
    drain();
    pixel_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_immediate", 1'b0, 24'h000000);
    @(posedge clk);
    #1;
    chk("reset_held_over_edge", 1'b0, 24'h000000);

    // Release mid-stream: first valid output one edge after first valid input
    @(negedge clk);
    pixel_valid = 1'b0;
    rst_n = 1'b1;
    e.vld = 1'b0; e.rgb = 24'h000000; e.tag = "post_reset_idle";
    sb.push_back(e);
    cycle(1'b1, 5'b00001, 2'b00, 24'hFF0000, "post_reset_first");
    drain();

    n_assert++;
    assert (sb.size() == 0)
      else begin
        n_fail++;
        $error("FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
